// File: rtl/mc_controller.sv
// mc_controller: control unit for the multi-cycle ARM-subset core.
// Moore sequencer with registered outputs, NZCV flag register and condition check.
module mc_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUControl,
    output logic        PCS
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_UNKNOWN
    } state_t;

    state_t     r_state, w_next;
    logic [3:0] r_flags;

    logic       r_pcw, r_mw, r_rw, r_irw, r_adr, r_pcs;
    logic [1:0] r_asa, r_asb, r_res;
    logic [2:0] r_alu;

    logic       w_pcw, w_mw, w_rw, w_irw, w_adr, w_pcs;
    logic [1:0] w_asa, w_asb, w_res;
    logic [2:0] w_alu;

    logic [3:0] w_cond, w_cmd;
    logic [1:0] w_op;
    logic [5:0] w_funct;
    logic       w_rd15, w_dp_ok, w_mem_ok, w_br, w_cmp;
    logic       w_condex, w_flag_wr;
    logic [2:0] w_alu_ctl;
    logic       w_n, w_z, w_c, w_v;
    logic       w_unused;

    assign w_cond   = Instr[31:28];
    assign w_op     = Instr[27:26];
    assign w_funct  = Instr[25:20];
    assign w_cmd    = w_funct[4:1];
    assign w_rd15   = (Instr[15:12] == 4'hf);
    assign w_unused = ^{Instr[19:16], Instr[11:0]};

    assign w_cmp    = (w_cmd == 4'b1010);
    assign w_dp_ok  = (w_op == 2'b00) &&
                      (w_cmd == 4'b0100 || w_cmd == 4'b0010 ||
                       w_cmd == 4'b0000 || w_cmd == 4'b1100 || w_cmp);
    assign w_mem_ok = (w_op == 2'b01) && !w_funct[5] && w_funct[3];
    assign w_br     = (w_op == 2'b10) && w_funct[5];

    assign RegSrc = {(w_op == 2'b01) && !w_funct[0], (w_op == 2'b10)};
    assign ImmSrc = (w_op == 2'b01) ? 2'b01 :
                    (w_op == 2'b10) ? 2'b10 : 2'b00;

    always_comb begin
        w_alu_ctl = 3'b000;
        case (w_cmd)
            4'b0010, 4'b1010: w_alu_ctl = 3'b001;
            4'b0000:          w_alu_ctl = 3'b010;
            4'b1100:          w_alu_ctl = 3'b011;
            default:          w_alu_ctl = 3'b000;
        endcase
    end

    // Condition is always judged against the flags held before this instruction
    assign {w_n, w_z, w_c, w_v} = r_flags;
    always_comb begin
        w_condex = 1'b0;
        case (w_cond)
            4'h0: w_condex = w_z;
            4'h1: w_condex = !w_z;
            4'h2: w_condex = w_c;
            4'h3: w_condex = !w_c;
            4'h4: w_condex = w_n;
            4'h5: w_condex = !w_n;
            4'h6: w_condex = w_v;
            4'h7: w_condex = !w_v;
            4'h8: w_condex = w_c && !w_z;
            4'h9: w_condex = !w_c || w_z;
            4'ha: w_condex = (w_n == w_v);
            4'hb: w_condex = (w_n != w_v);
            4'hc: w_condex = !w_z && (w_n == w_v);
            4'hd: w_condex = w_z || (w_n != w_v);
            4'he: w_condex = 1'b1;
            default: w_condex = 1'b0;
        endcase
    end

    assign w_flag_wr = (r_state == S_EXECR || r_state == S_EXECI) &&
                       w_funct[0] && w_condex;

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:   w_next = S_DECODE;
            S_DECODE: begin
                if (w_mem_ok)     w_next = S_MEMADR;
                else if (w_dp_ok) w_next = w_funct[5] ? S_EXECI : S_EXECR;
                else if (w_br)    w_next = S_BRANCH;
                else              w_next = S_UNKNOWN;
            end
            S_MEMADR:  w_next = w_funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: w_next = S_MEMWB;
            S_EXECR,
            S_EXECI:   w_next = S_ALUWB;
            default:   w_next = S_FETCH;
        endcase
    end

    // Outputs of the state being entered, so they register glitch-free
    always_comb begin
        w_pcw = 1'b0;
        w_mw  = 1'b0;
        w_rw  = 1'b0;
        w_irw = 1'b0;
        w_adr = 1'b0;
        w_pcs = 1'b0;
        w_asa = 2'b00;
        w_asb = 2'b00;
        w_res = 2'b00;
        w_alu = 3'b000;
        case (w_next)
            S_FETCH: begin
                w_irw = 1'b1;
                w_pcw = 1'b1;
                w_asa = 2'b01;
                w_asb = 2'b10;
            end
            S_DECODE: begin
                w_asa = 2'b01;
                w_asb = 2'b10;
                w_res = 2'b10;
            end
            S_MEMADR:   w_asb = 2'b01;
            S_MEMREAD:  w_adr = 1'b1;
            S_MEMWB: begin
                w_res = 2'b01;
                w_pcs = w_rd15;
                w_pcw = w_rd15 && w_condex;
                w_rw  = !w_rd15 && w_condex;
            end
            S_MEMWRITE: begin
                w_adr = 1'b1;
                w_mw  = w_condex;
            end
            S_EXECR:    w_alu = w_alu_ctl;
            S_EXECI: begin
                w_asb = 2'b01;
                w_alu = w_alu_ctl;
            end
            S_ALUWB: begin
                w_pcs = !w_cmp && w_rd15;
                w_pcw = !w_cmp && w_rd15 && w_condex;
                w_rw  = !w_cmp && !w_rd15 && w_condex;
            end
            S_BRANCH: begin
                w_asb = 2'b01;
                w_pcw = w_condex;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_flags <= 4'b0000;
            r_pcw   <= 1'b1;
            r_mw    <= 1'b0;
            r_rw    <= 1'b0;
            r_irw   <= 1'b1;
            r_adr   <= 1'b0;
            r_pcs   <= 1'b0;
            r_asa   <= 2'b01;
            r_asb   <= 2'b10;
            r_res   <= 2'b00;
            r_alu   <= 3'b000;
        end else begin
            r_state <= w_next;
            if (w_flag_wr)
                r_flags <= ALUFlags;
            r_pcw   <= w_pcw;
            r_mw    <= w_mw;
            r_rw    <= w_rw;
            r_irw   <= w_irw;
            r_adr   <= w_adr;
            r_pcs   <= w_pcs;
            r_asa   <= w_asa;
            r_asb   <= w_asb;
            r_res   <= w_res;
            r_alu   <= w_alu;
        end
    end

    assign PCWrite    = r_pcw;
    assign MemWrite   = r_mw;
    assign RegWrite   = r_rw;
    assign IRWrite    = r_irw;
    assign AdrSrc     = r_adr;
    assign PCS        = r_pcs;
    assign ALUSrcA    = r_asa;
    assign ALUSrcB    = r_asb;
    assign ResultSrc  = r_res;
    assign ALUControl = r_alu;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: random and directed instructions checked cycle by cycle
// against an instruction-level reference model of the control unit.
module tb_mc_controller;
    typedef logic [18:0] vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags = 4'h0;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, PCS;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0]  ALUControl;

    int   n_checks = 0;
    int   n_errors = 0;
    logic [3:0] m_flags = 4'h0;
    vec_t exp_q[$];
    logic [3:0] cmd_tab [0:4] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};

    mc_controller dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .PCS(PCS)
    );

    always #5 clk = ~clk;

    vec_t obs;
    assign obs = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
                  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, PCS};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic vec_t mk(bit pcw, bit mw, bit rw, bit irw, bit adr,
                                logic [1:0] rsrc, logic [1:0] asa,
                                logic [1:0] asb, logic [1:0] res,
                                logic [1:0] imm, logic [2:0] alu, bit pcs);
        return {pcw, mw, rw, irw, adr, rsrc, asa, asb, res, imm, alu, pcs};
    endfunction

    function automatic bit cond_ok(logic [3:0] c, logic [3:0] f);
        bit n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'ha: return n == v;
            4'hb: return n != v;
            4'hc: return !z && (n == v);
            4'hd: return z || (n != v);
            4'he: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Builds the expected per-cycle output list; returns whether flags load
    function automatic bit build(logic [31:0] ins);
        logic [1:0] op, rsrc, imm;
        logic [5:0] fn;
        logic [3:0] cmd;
        logic [2:0] alu;
        bit ce, rd15, cmp, dp, mem, br;
        op   = ins[27:26];
        fn   = ins[25:20];
        cmd  = fn[4:1];
        rd15 = (ins[15:12] == 4'hf);
        ce   = cond_ok(ins[31:28], m_flags);
        cmp  = (cmd == 4'b1010);
        dp   = (op == 2'd0) && (cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010});
        mem  = (op == 2'd1) && !fn[5] && fn[3];
        br   = (op == 2'd2) && fn[5];
        rsrc = {op == 2'd1 && !fn[0], op == 2'd2};
        imm  = (op == 2'd1) ? 2'b01 : (op == 2'd2) ? 2'b10 : 2'b00;
        alu  = (cmd == 4'b0010 || cmp) ? 3'd1 : (cmd == 4'b0000) ? 3'd2 :
               (cmd == 4'b1100) ? 3'd3 : 3'd0;
        exp_q = {};
        exp_q.push_back(mk(1, 0, 0, 1, 0, rsrc, 2'b01, 2'b10, 2'b00, imm, 3'd0, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 0, rsrc, 2'b01, 2'b10, 2'b10, imm, 3'd0, 0));
        if (dp) begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, rsrc, 2'b00, fn[5] ? 2'b01 : 2'b00,
                               2'b00, imm, alu, 0));
            exp_q.push_back(mk(!cmp && rd15 && ce, 0, !cmp && !rd15 && ce, 0, 0,
                               rsrc, 2'b00, 2'b00, 2'b00, imm, 3'd0, !cmp && rd15));
            return fn[0] && ce;
        end else if (mem) begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, rsrc, 2'b00, 2'b01, 2'b00, imm, 3'd0, 0));
            if (fn[0]) begin
                exp_q.push_back(mk(0, 0, 0, 0, 1, rsrc, 2'b00, 2'b00, 2'b00, imm, 3'd0, 0));
                exp_q.push_back(mk(rd15 && ce, 0, !rd15 && ce, 0, 0, rsrc, 2'b00,
                                   2'b00, 2'b01, imm, 3'd0, rd15));
            end else begin
                exp_q.push_back(mk(0, ce, 0, 0, 1, rsrc, 2'b00, 2'b00, 2'b00, imm, 3'd0, 0));
            end
        end else if (br) begin
            exp_q.push_back(mk(ce, 0, 0, 0, 0, rsrc, 2'b00, 2'b01, 2'b00, imm, 3'd0, 0));
        end else begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, rsrc, 2'b00, 2'b00, 2'b00, imm, 3'd0, 0));
        end
        return 1'b0;
    endfunction

    // Entered just after a rising edge with the DUT in FETCH
    task automatic run_instr(input string name, input logic [31:0] ins,
                             input logic [3:0] fl, input int abort_at);
        bit upd;
        upd = build(ins);
        Instr = ins;
        for (int i = 0; i < exp_q.size(); i++) begin
            ALUFlags = (i == 2) ? fl : 4'($urandom);
            @(negedge clk);
            check($sformatf("%s c%0d", name, i), 32'(obs), 32'(exp_q[i]));
            if (i == abort_at) begin
                reset = 1'b1;
                #1;
                check($sformatf("%s abort", name), 32'(obs), 32'(exp_q[0]));
                @(posedge clk);
                #1;
                reset = 1'b0;
                m_flags = 4'h0;
                return;
            end
            @(posedge clk);
            #1;
        end
        if (upd)
            m_flags = fl;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [3:0]  c, rd, cmd;
        logic [31:0] lo;
        int k;
        k  = $urandom_range(0, 9);
        c  = ($urandom_range(0, 1) == 0) ? 4'he : 4'($urandom);
        rd = ($urandom_range(0, 3) == 0) ? 4'hf : 4'($urandom);
        lo = $urandom;
        case (k)
            0, 1, 2, 3: begin
                cmd = cmd_tab[$urandom_range(0, 4)];
                return {c, 2'b00, 1'($urandom), cmd, 1'($urandom), lo[19:16], rd, lo[11:0]};
            end
            4: begin
                cmd = 4'($urandom);
                while (cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010})
                    cmd = 4'($urandom);
                return {c, 2'b00, 1'($urandom), cmd, 1'($urandom), lo[19:16], rd, lo[11:0]};
            end
            5: return {c, 8'h59, lo[19:16], rd, lo[11:0]};
            6: return {c, 8'h58, lo[19:16], rd, lo[11:0]};
            7, 8: return {c, 3'b101, lo[24:0]};
            default: return {c, 2'b11, lo[25:0]};
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Instr = 'x;
        #1 reset = 1'b1;
        #2;
        check("rst PCWrite", 32'(PCWrite), 1);
        check("rst IRWrite", 32'(IRWrite), 1);
        check("rst MemWrite", 32'(MemWrite), 0);
        check("rst RegWrite", 32'(RegWrite), 0);
        check("rst ALUSrcB", 32'(ALUSrcB), 2);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        run_instr("beq0", 32'h0A000002, 4'h0, -1);
        run_instr("add", 32'hE0821003, 4'h3, -1);
        run_instr("subs z", 32'hE2500000, 4'b0100, -1);
        run_instr("beq1", 32'h0A000002, 4'h0, -1);
        run_instr("subs nz", 32'hE2500000, 4'b0000, -1);
        run_instr("beq2", 32'h0A000002, 4'h0, -1);
        run_instr("ldr", 32'hE5903008, 4'h0, -1);
        run_instr("subs z2", 32'hE2500000, 4'b0100, -1);
        run_instr("strne z", 32'h15821004, 4'h0, -1);
        run_instr("subs nz2", 32'hE2500000, 4'b0000, -1);
        run_instr("strne nz", 32'h15821004, 4'h0, -1);
        run_instr("cmp abort", 32'hE3500000, 4'b0100, 2);
        run_instr("beq post", 32'h0A000002, 4'h0, -1);

        for (int n = 0; n < 400; n++)
            run_instr($sformatf("r%0d", n), rand_instr(), 4'($urandom), -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mc_controller.md
# mc_controller

Control unit for the multi-cycle ARM-subset core. Decodes the latched instruction word and the ALU flags returned by the datapath, and sequences each instruction through a Moore main FSM. Drives every datapath select and enable plus the memory write strobe. Holds the architectural NZCV flag register and evaluates condition codes.

## Interface
- No parameters.
- clk  input  1  core clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high; forces FSM to FETCH and flags to 0000
- Instr  input  32  instruction register contents from the datapath
- ALUFlags  input  4  {N,Z,C,V} of the current ALU operation (combinational from datapath)
- PCWrite  output  1  PC register enable
- MemWrite  output  1  data memory write strobe
- RegWrite  output  1  register file write enable
- IRWrite  output  1  instruction register enable
- AdrSrc  output  1  0 = PC, 1 = ALUOut as memory address
- RegSrc  output  2  [0]=1 reads R15 as RA1; [1]=1 reads Instr[15:12] as RA2
- ALUSrcA  output  2  00 = A register, 01 = PC
- ALUSrcB  output  2  00 = B register, 01 = ExtImm, 10 = constant 4
- ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = PC
- ImmSrc  output  2  00 = imm8, 01 = imm12, 10 = imm24 branch
- ALUControl  output  3  000 ADD, 001 SUB, 010 AND, 011 ORR
- PCS  output  1  0 = PC loads ALUResult, 1 = PC loads Result

## Operation
- Instruction fields: cond=Instr[31:28], op=Instr[27:26], funct=Instr[25:20], Rd=Instr[15:12].
- Data-processing (op 00): funct[5] selects immediate. cmd=funct[4:1]. Supported commands: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP. CMP uses SUB and never writes a register. Any other cmd decodes as unsupported.
- Memory (op 01): funct[0]=L. Only immediate offset (funct[5]=0) with positive offset is supported. Address is always Rn+imm12 (ADD).
- Branch (op 10, Instr[25]=1): target = A (R15) + ExtImm.
- op 11 decodes as unsupported.
- Decoder outputs are combinational from Instr: RegSrc[0]=branch, RegSrc[1]=store, ImmSrc = 00/01/10 per class.
- CondEx from cond and the flag register: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL. Code 1111 evaluates false.
- States and Moore outputs (unlisted outputs are 0):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ADD, PCS=0, PCWrite=1 → DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10. Next state: MEMADR (mem), EXECUTER or EXECUTEI (dp by funct[5]), BRANCH, or UNKNOWN.
  - MEMADR: ALUSrcA=00, ALUSrcB=01, ADD → MEMREAD if L, else MEMWRITE.
  - MEMREAD: AdrSrc=1 → MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=CondEx. If Rd=15, RegWrite=0 and instead PCS=1, PCWrite=CondEx → FETCH.
  - MEMWRITE: AdrSrc=1, MemWrite=CondEx → FETCH.
  - EXECUTER / EXECUTEI: ALUSrcA=00, ALUSrcB=00/01, ALUControl per cmd. Flags load ALUFlags at the clock edge when S=funct[0]=1 and CondEx → ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=CondEx & !CMP. If Rd=15 and not CMP, RegWrite=0 and instead PCS=1, PCWrite=CondEx → FETCH.
  - BRANCH: ALUSrcA=00, ALUSrcB=01, ADD, PCS=0, PCWrite=CondEx → FETCH.
  - UNKNOWN: no enables → FETCH.
- Flags change only in EXECUTER/EXECUTEI. CondEx always uses the flags from before the current instruction.

## Timing
- Reset: state=FETCH, flags=0000 immediately (asynchronous). While reset is held, outputs are the FETCH values; MemWrite=0 and RegWrite=0.
- Instruction lengths in cycles: data-processing 4, LDR 5, STR 4, B 3, unsupported 3. Failed condition has the same length with writes suppressed.
- Reset asserted mid-instruction aborts it. FETCH follows on the first edge after deassertion. No partial write is issued after reset.
- All outputs are glitch-free functions of state and registered Instr/flags; no combinational path from ALUFlags to any output.

## Test plan
- Reset with Instr=X: state FETCH, IRWrite=1, PCWrite=1, MemWrite=0, RegWrite=0, flags 0000.
- ADD R1,R2,R3 (0xE0821003): FETCH→DECODE→EXECUTER→ALUWB. In EXECUTER, ALUControl=000 and ALUSrcB=00. In ALUWB, RegWrite=1 and ResultSrc=00.
- SUBS R0,R0,#0 (0xE2500000) with ALUFlags=0100 in EXECUTEI, then BEQ (0x0A000002): flags=0100, and BRANCH asserts PCWrite=1 with PCS=0. With flags 0000, the same BEQ gives PCWrite=0 in BRANCH.
- LDR R3,[R0,#8] (0xE5903008): 5-cycle sequence. MEMREAD has AdrSrc=1. MEMWB has ResultSrc=01 and RegWrite=1. ImmSrc=01 throughout.
- STRNE R1,[R2,#4] (0x15821004) with Z=1: MEMWRITE has AdrSrc=1 and MemWrite=0. With Z=0: MemWrite=1 and RegSrc[1]=1.
- Assert reset during EXECUTER of CMP: flags are not updated, and the next post-reset cycle is FETCH with RegWrite=0.
